// File: rtl/seq_gen_1011.sv
// Frame transmitter for the 1011 detector. Each accepted payload word is sent
// as the sync pattern 1011 followed by the payload, MSB first. A 0 is stuffed
// wherever a 1 would otherwise complete 1011, so the only 1011 in the stream
// ends on the 4th sync bit of each frame.
module seq_gen_1011 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              stuff_flag,
    output logic              frame_done
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [3:0] SyncPat = 4'b1011;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StPayload
    } state_e;

    state_e            state;
    logic [1:0]        sync_idx;
    logic [IdxW-1:0]   bit_idx;
    logic [DATA_W-1:0] data_q;
    // Last three presented bits, newest (the current out_bit) in the LSB.
    logic [2:0]        hist;

    logic accept;
    logic sched;
    logic sched_bit;
    logic last_sync;
    logic do_stuff;
    logic next_bit;

    // The state moves to StIdle on the edge that presents the last payload
    // bit, so ready is high during the frame_done cycle.
    assign data_ready = !reset && (state == StIdle);
    assign accept     = data_valid && data_ready;

    // Pick the bit scheduled for the coming edge and decide whether to stuff.
    always_comb begin
        sched     = 1'b0;
        sched_bit = 1'b0;
        last_sync = 1'b0;
        case (state)
            StIdle: begin
                // A word accepted on this edge schedules its first sync bit now.
                if (accept) begin
                    sched     = 1'b1;
                    sched_bit = SyncPat[3];
                end
            end
            StSync: begin
                sched     = 1'b1;
                sched_bit = SyncPat[~sync_idx];
                last_sync = (sync_idx == 2'd3);
            end
            StPayload: begin
                sched     = 1'b1;
                sched_bit = data_q[bit_idx];
            end
            default: begin
                sched = 1'b0;
            end
        endcase
        // The 4th sync bit is the one intended 1011 and is never stuffed.
        do_stuff = sched && sched_bit && !last_sync && (hist == 3'b101);
        next_bit = sched && sched_bit && !do_stuff;
    end

    // Frame FSM, history shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            sync_idx   <= 2'd0;
            bit_idx    <= '0;
            data_q     <= '0;
            hist       <= 3'b000;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            stuff_flag <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            hist       <= {hist[1:0], next_bit};
            out_bit    <= next_bit;
            out_valid  <= sched;
            stuff_flag <= do_stuff;
            frame_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        data_q   <= data_in;
                        state    <= StSync;
                        // A stuffed bit leaves sync bit 0 still scheduled.
                        sync_idx <= do_stuff ? 2'd0 : 2'd1;
                    end
                end
                StSync: begin
                    if (!do_stuff) begin
                        if (sync_idx == 2'd3) begin
                            state   <= StPayload;
                            bit_idx <= IdxW'(DATA_W - 1);
                        end
                        sync_idx <= sync_idx + 2'd1;
                    end
                end
                StPayload: begin
                    if (!do_stuff) begin
                        if (bit_idx == '0) begin
                            frame_done <= 1'b1;
                            state      <= StIdle;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_1011.sv
// Bench for seq_gen_1011: each accepted word pushes its expected frame
// (bit, stuff, done, 4th-sync marker) to a queue; a negedge monitor pops one
// entry per cycle and compares, and a reference 1011 window checks the stream.
module tb_seq_gen_1011;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic b;
        logic stf;
        logic done;
        logic sync4;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          out_bit;
    logic          out_valid;
    logic          stuff_flag;
    logic          frame_done;

    int   n_vec = 0;
    int   n_err = 0;
    rec_t q[$];
    logic [2:0]  exp_hist = 3'b000;
    logic        clr = 1'b0;
    logic        started = 1'b0;
    int          acc_cnt = 0;
    logic [3:0]  win = 4'b0000;
    logic [63:0] cap = '0;
    logic [63:0] scap = '0;
    int          cap_n = 0;

    seq_gen_1011 #(.DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .stuff_flag (stuff_flag),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected frame from the bit sequence and the stream history at accept.
    function automatic void push_frame(logic [DW-1:0] w, logic [2:0] h0);
        logic [2:0] h;
        logic [3:0] sync;
        logic       b;
        rec_t       r;
        h    = h0;
        sync = 4'b1011;
        for (int i = 0; i < 4 + int'(DW); i++) begin
            b = (i < 4) ? sync[3 - i] : w[int'(DW) - 1 - (i - 4)];
            if (b && h == 3'b101 && i != 3) begin
                r = '{b: 1'b0, stf: 1'b1, done: 1'b0, sync4: 1'b0};
                q.push_back(r);
                h = {h[1:0], 1'b0};
            end
            r = '{b: b, stf: 1'b0, done: (i == 3 + int'(DW)), sync4: (i == 3)};
            q.push_back(r);
            h = {h[1:0], b};
        end
    endfunction

    // Per-cycle compare, then predict what the next rising edge will do.
    always @(negedge clk) begin
        rec_t r;
        logic ev;
        r  = '0;
        ev = 1'b0;
        if (started) begin
            if (q.size() > 0) begin
                r  = q.pop_front();
                ev = 1'b1;
            end
            check_eq("out_valid", 64'(out_valid), 64'(ev));
            check_eq("out_bit", 64'(out_bit), 64'(r.b));
            check_eq("stuff_flag", 64'(stuff_flag), 64'(r.stf));
            check_eq("frame_done", 64'(frame_done), 64'(r.done));
            check_eq("data_ready", 64'(data_ready), 64'(!reset && q.size() == 0));
            win = {win[2:0], out_bit};
            check_eq("detector", 64'(win == 4'b1011), 64'(r.sync4));
            if (out_valid === 1'b1) begin
                cap   = {cap[62:0], out_bit};
                scap  = {scap[62:0], stuff_flag};
                cap_n = cap_n + 1;
            end
            exp_hist = clr ? 3'b000 : {exp_hist[1:0], r.b};
        end
        clr = 1'b0;
        if (reset) begin
            q.delete();
            clr     = 1'b1;
            started = 1'b1;
        end else if (started && data_valid && q.size() == 0) begin
            push_frame(data_in, exp_hist);
            acc_cnt = acc_cnt + 1;
        end
    end

    task automatic send(logic [DW-1:0] w, bit hold);
        int a0;
        int n;
        a0 = acc_cnt;
        n  = 0;
        data_in    = w;
        data_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (acc_cnt == a0 && n < 300);
        if (acc_cnt == a0) check_eq("accept_timeout", 64'(acc_cnt), 64'(a0 + 1));
        if (!hold) data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || data_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check_eq("idle_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(string tag, int n0, int len, logic [63:0] eb, logic [63:0] es);
        logic [63:0] mask;
        mask = (64'd1 << len) - 64'd1;
        check_eq({tag, "_len"}, 64'(cap_n - n0), 64'(len));
        check_eq({tag, "_bits"}, cap & mask, eb);
        check_eq({tag, "_stuff"}, scap & mask, es);
    endtask

    initial begin
        int n0;
        bit hold;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single frame of zeros: plain 1011 00000000.
        n0 = cap_n;
        send(8'h00, 1'b0);
        wait_idle();
        check_stream("zero", n0, 12, 64'hB00, 64'h0);

        // 0x5A needs one stuff bit: 1011 0101 0 1010.
        n0 = cap_n;
        send(8'h5A, 1'b0);
        wait_idle();
        check_stream("stuff5a", n0, 13, 64'h16AA, 64'h0010);

        // Back-to-back 0x05 then 0xFF, stuff bit ahead of the second sync.
        n0 = cap_n;
        send(8'h05, 1'b1);
        send(8'hFF, 1'b0);
        wait_idle();
        check_stream("b2b", n0, 25, 64'(25'b1011_0000_0101_0_1011_1111_1111),
                     64'(25'h1000));

        // Reset while the 3rd payload bit of 0xA5 is on the line.
        n0 = cap_n;
        send(8'hA5, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_stream("abort", n0, 7, 64'h5D, 64'h0);
        n0 = cap_n;
        send(8'h00, 1'b0);
        wait_idle();
        check_stream("after_rst", n0, 12, 64'hB00, 64'h0);

        // Random traffic, mixing back-to-back and idle gaps.
        for (int i = 0; i < 50; i++) begin
            hold = 1'($urandom_range(0, 1));
            send(DW'($urandom), hold);
            if (!hold) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
